// File: rtl/lcd_pkg.sv
// Constants and state encoding shared by the LCD write path (lcd_init, control, arbiter).
package lcd_pkg;

  localparam int unsigned          LCD_DW        = 9;
  localparam logic [LCD_DW-1:0]    LCD_DATA_IDLE = 9'b0_0000_0000;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    XFER,
    REL
  } arb_state_t;

  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/lcd_write_arbiter_if.sv
// Requester-side and write-engine-side signals of the shared lcd_write arbiter.
interface lcd_write_arbiter_if
  import lcd_pkg::*;
#(
  parameter int unsigned NREQ = 3,
  parameter int unsigned DW   = LCD_DW
);

  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    en_in;
  logic [NREQ-1:0]    last_in;
  logic [NREQ*DW-1:0] data_in;
  logic [NREQ-1:0]    grant;
  logic [NREQ-1:0]    done_out;
  logic [DW-1:0]      data;
  logic               en_write;
  logic               wr_done;

  modport slave (
    input  req, en_in, last_in, data_in, wr_done,
    output grant, done_out, data, en_write
  );

  modport master (
    output req, en_in, last_in, data_in, wr_done,
    input  grant, done_out, data, en_write
  );

endinterface

// File: rtl/lcd_write_arbiter_rr_pick.sv
// Combinational round-robin picker: first eligible requester at or after ptr, wrapping.
module rr_pick #(
  parameter int unsigned NREQ = 3,
  parameter int unsigned IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req_elig,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] onehot,
  output logic [IW-1:0]   idx,
  output logic            valid
);

  always_comb begin
    int unsigned pos;
    pos    = 0;
    onehot = '0;
    idx    = '0;
    valid  = 1'b0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      pos = (32'(ptr) + k) % NREQ;
      if (!valid && req_elig[pos]) begin
        valid       = 1'b1;
        onehot[pos] = 1'b1;
        idx         = IW'(pos);
      end
    end
  end

endmodule

// File: rtl/lcd_write_arbiter.sv
// Burst arbiter sharing one lcd_write engine between init, picture and character sources.
module lcd_write_arbiter
  import lcd_pkg::*;
#(
  parameter int unsigned    NREQ      = 3,
  parameter int unsigned    DW        = LCD_DW,
  parameter logic [DW-1:0]  DATA_IDLE = LCD_DATA_IDLE,
  parameter logic [15:0]    TIMEOUT   = 16'd50_000
) (
  input  logic                sys_clk_50MHz,
  input  logic                sys_rst,
  lcd_write_arbiter_if.slave  bus,
  input  logic                init_done,
  output logic                busy,
  output logic                err
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned TW = (TIMEOUT == 16'd0) ? 1 : $clog2(32'(TIMEOUT) + 1);

  arb_state_t      state_q;
  logic [IW-1:0]   gidx_q;
  logic [NREQ-1:0] grant_q;
  logic [DW-1:0]   data_q;
  logic            en_write_q;
  logic            last_q;
  logic            err_q;
  logic [TW-1:0]   tcnt_q;
  logic [TW-1:0]   tcnt_d;

  logic [NREQ-1:0] elig;
  logic [NREQ-1:0] pick_oh;
  logic [IW-1:0]   pick_idx;
  logic [IW-1:0]   ptr;
  logic            pick_vld;
  logic            en_g;
  logic            en_other;
  logic            req_g;
  logic            last_g;
  logic            tmo_hit;
  logic [DW-1:0]   word_g;

  // Until the panel is initialised only the init sequencer may own the engine.
  assign elig = init_done ? bus.req : (bus.req & NREQ'(1));
  assign ptr  = IW'(wrap_inc(32'(gidx_q), NREQ));

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req_elig (elig),
    .ptr      (ptr),
    .onehot   (pick_oh),
    .idx      (pick_idx),
    .valid    (pick_vld)
  );

  assign en_g     = bus.en_in[gidx_q];
  assign en_other = |(bus.en_in & ~grant_q);
  assign req_g    = bus.req[gidx_q];
  assign last_g   = bus.last_in[gidx_q];
  assign word_g   = bus.data_in[gidx_q*DW +: DW];

  assign tcnt_d  = tcnt_q + 1'b1;
  assign tmo_hit = (TIMEOUT != 16'd0) && (tcnt_d == TW'(TIMEOUT));

  always_ff @(posedge sys_clk_50MHz or posedge sys_rst) begin
    if (sys_rst) begin
      state_q    <= IDLE;
      gidx_q     <= IW'(NREQ - 1);
      grant_q    <= '0;
      data_q     <= DATA_IDLE;
      en_write_q <= 1'b0;
      last_q     <= 1'b0;
      err_q      <= 1'b0;
      tcnt_q     <= '0;
    end else begin
      en_write_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pick_vld) begin
            gidx_q  <= pick_idx;
            grant_q <= pick_oh;
            tcnt_q  <= '0;
            state_q <= GRANT;
          end
        end
        GRANT: begin
          if (en_other) begin
            err_q <= 1'b1;
          end
          // A withdrawn request is a clean release; a silent one is a timeout.
          if (!req_g) begin
            grant_q <= '0;
            state_q <= REL;
          end else if (en_g) begin
            data_q     <= word_g;
            en_write_q <= 1'b1;
            last_q     <= last_g;
            tcnt_q     <= '0;
            state_q    <= XFER;
          end else if (tmo_hit) begin
            err_q   <= 1'b1;
            grant_q <= '0;
            state_q <= REL;
          end else begin
            tcnt_q <= tcnt_d;
          end
        end
        XFER: begin
          if (en_g) begin
            err_q <= 1'b1;
          end
          if (bus.wr_done) begin
            if (last_q) begin
              grant_q <= '0;
              state_q <= REL;
            end else begin
              tcnt_q  <= '0;
              state_q <= GRANT;
            end
          end
        end
        REL: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.grant    = grant_q;
  assign bus.data     = data_q;
  assign bus.en_write = en_write_q;
  assign bus.done_out = grant_q & {NREQ{bus.wr_done && (state_q == XFER)}};
  assign busy         = (state_q != IDLE);
  assign err          = err_q;

  a_grant_onehot0 : assert property (
    @(posedge sys_clk_50MHz) disable iff (sys_rst) $onehot0(grant_q)
  );

  a_write_needs_grant : assert property (
    @(posedge sys_clk_50MHz) disable iff (sys_rst) en_write_q |-> (grant_q != '0)
  );

endmodule

// File: tb/tb_lcd_write_arbiter.sv
// Randomised self-checking bench for lcd_write_arbiter against a burst-level reference model.
module tb_lcd_write_arbiter;

  localparam int unsigned NREQ = 3;
  localparam int unsigned DW   = 9;
  localparam int unsigned DINW = NREQ * DW;

  logic clk = 1'b0;
  logic rst;
  logic init_done;
  logic busy;
  logic err;

  int n_checks = 0;
  int n_fail   = 0;
  int last_win;

  lcd_write_arbiter_if #(.NREQ(NREQ), .DW(DW)) bus ();

  lcd_write_arbiter #(
    .NREQ      (NREQ),
    .DW        (DW),
    .DATA_IDLE (9'h000),
    .TIMEOUT   (16'd8)
  ) dut (
    .sys_clk_50MHz (clk),
    .sys_rst       (rst),
    .bus           (bus),
    .init_done     (init_done),
    .busy          (busy),
    .err           (err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NREQ-1:0] oh(input int i);
    logic [NREQ-1:0] v;
    v = '0;
    if (i >= 0) v[i] = 1'b1;
    return v;
  endfunction

  // Reference: next owner is the first eligible requester after the previous owner.
  function automatic int rr_next(input int last, input logic [NREQ-1:0] rq, input logic idone);
    for (int k = 1; k <= int'(NREQ); k++) begin
      int i;
      i = (last + k) % int'(NREQ);
      if (rq[i] && (idone || i == 0)) return i;
    end
    return -1;
  endfunction

  task automatic expect_grant(input string tag);
    int w;
    w = rr_next(last_win, bus.req, init_done);
    check_eq(tag, bus.grant, oh(w));
    if (w >= 0) last_win = w;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_grant"}, bus.grant, 0);
    check_eq({tag, "_done"}, bus.done_out, 0);
    check_eq({tag, "_en_write"}, bus.en_write, 0);
    check_eq({tag, "_data"}, bus.data, 9'h000);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_err"}, err, 0);
  endtask

  task automatic do_reset();
    bus.req     = '0;
    bus.en_in   = '0;
    bus.last_in = '0;
    bus.data_in = '0;
    bus.wr_done = 1'b0;
    rst = 1'b1;
    step();
    step();
    check_reset_outputs("reset");
    rst = 1'b0;
    last_win = NREQ - 1;
  endtask

  // Runs a granted burst of n words; returns in the release cycle.
  task automatic run_burst(input int r, input int n, input int max_gap, input int raise_init_at,
                           output int n_en, output int n_done);
    logic [DW-1:0] w;
    int gap;
    int lat;
    n_en   = 0;
    n_done = 0;
    for (int k = 0; k < n; k++) begin
      gap = $urandom_range(max_gap, 0);
      repeat (gap) begin
        step();
        check_eq("gap_grant", bus.grant, oh(r));
        check_eq("gap_en_write", bus.en_write, 0);
      end
      bus.data_in = DINW'($urandom);
      bus.en_in   = oh(r);
      bus.last_in = (k == n - 1) ? oh(r) : '0;
      w = bus.data_in[r*DW +: DW];
      if (k == raise_init_at) init_done = 1'b1;
      step();
      bus.en_in   = '0;
      bus.last_in = '0;
      if (bus.en_write) n_en++;
      check_eq("word_en_write", bus.en_write, 1);
      check_eq("word_data", bus.data, w);
      check_eq("word_grant", bus.grant, oh(r));
      lat = $urandom_range(3, 0);
      repeat (lat) begin
        bus.data_in = DINW'($urandom);
        step();
        check_eq("hold_en_write", bus.en_write, 0);
        check_eq("hold_data", bus.data, w);
      end
      bus.wr_done = 1'b1;
      #3;
      check_eq("done_out", bus.done_out, oh(r));
      if (bus.done_out[r]) n_done++;
      step();
      bus.wr_done = 1'b0;
      check_eq("post_en_write", bus.en_write, 0);
      if (k == n - 1) begin
        check_eq("rel_grant", bus.grant, 0);
        check_eq("rel_busy", busy, 1);
      end else begin
        check_eq("next_grant", bus.grant, oh(r));
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ne;
    int nd;
    int nw;
    logic [NREQ-1:0] rq;

    rst       = 1'b1;
    init_done = 1'b0;
    do_reset();

    // Init lockout: only requester 0 may win while init_done is low.
    bus.req = 3'b110;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) begin
        bus.wr_done = 1'b1;
        #3;
        check_eq("idle_stray_done", bus.done_out, 0);
      end
      step();
      bus.wr_done = 1'b0;
      check_eq("lockout_grant", bus.grant, 0);
      check_eq("lockout_busy", busy, 0);
    end
    bus.req = 3'b111;
    step();
    check_eq("init_grant", bus.grant, 3'b001);
    expect_grant("init_grant_model");
    run_burst(0, 13, 2, 6, ne, nd);
    check_eq("burst13_en_count", ne, 13);
    check_eq("burst13_done_count", nd, 13);
    bus.req = 3'b110;
    step();
    check_eq("burst13_idle_grant", bus.grant, 0);
    step();
    expect_grant("after_init_grant");

    // Requester 1 withdraws while granted: clean release, no error.
    bus.req = 3'b100;
    step();
    check_eq("drop_grant", bus.grant, 0);
    check_eq("drop_busy", busy, 1);
    check_eq("drop_err", err, 0);
    step();
    step();
    expect_grant("after_drop_grant");
    run_burst(2, 1, 2, -1, ne, nd);
    bus.req = '0;
    step();

    // Randomised bursts from random request sets.
    for (int it = 0; it < 40; it++) begin
      rq = NREQ'($urandom_range(7, 1));
      bus.req = rq;
      step();
      expect_grant("rand_grant");
      check_eq("rand_busy", busy, 1);
      nw = $urandom_range(4, 1);
      run_burst(last_win, nw, 3, -1, ne, nd);
      check_eq("rand_en_count", ne, nw);
      check_eq("rand_done_count", nd, nw);
      bus.req = '0;
      step();
      check_eq("rand_idle_grant", bus.grant, 0);
      check_eq("rand_idle_busy", busy, 0);
      if (it % 5 == 0) begin
        bus.wr_done = 1'b1;
        #3;
        check_eq("rand_stray_done", bus.done_out, 0);
        bus.wr_done = 1'b0;
      end
    end
    check_eq("rand_err", err, 0);

    // Round-robin with every requester asking continuously.
    do_reset();
    bus.req = 3'b111;
    step();
    check_eq("rr_first", bus.grant, 3'b001);
    expect_grant("rr_first_model");
    for (int b = 0; b < 6; b++) begin
      run_burst(last_win, 1, 1, -1, ne, nd);
      step();
      check_eq("rr_idle_grant", bus.grant, 0);
      step();
      check_eq("rr_order", bus.grant, oh((b + 1) % 3));
      expect_grant("rr_model");
    end
    bus.req = '0;
    step();
    step();
    step();

    // Timeout: requester 1 is granted and never sends a word.
    bus.req = 3'b010;
    step();
    expect_grant("tmo_grant");
    check_eq("tmo_grant_is_1", bus.grant, 3'b010);
    for (int i = 1; i < 8; i++) begin
      if (i == 3) begin
        bus.wr_done = 1'b1;
        #3;
        check_eq("grant_stray_done", bus.done_out, 0);
      end
      step();
      bus.wr_done = 1'b0;
      check_eq("tmo_hold_grant", bus.grant, 3'b010);
      check_eq("tmo_hold_err", err, 0);
    end
    bus.req = 3'b110;
    step();
    check_eq("tmo_rel_grant", bus.grant, 0);
    check_eq("tmo_err", err, 1);
    check_eq("tmo_busy", busy, 1);
    step();
    check_eq("tmo_idle_grant", bus.grant, 0);
    step();
    expect_grant("tmo_next_grant");
    check_eq("tmo_next_is_2", bus.grant, 3'b100);
    bus.req = '0;
    step();
    check_eq("tmo_err_sticky", err, 1);
    step();

    // Protocol violations.
    do_reset();
    bus.req = 3'b010;
    step();
    expect_grant("pv_grant");
    bus.data_in = DINW'($urandom);
    bus.en_in   = 3'b100;
    step();
    bus.en_in = '0;
    check_eq("pv_no_write", bus.en_write, 0);
    check_eq("pv_err", err, 1);
    check_eq("pv_grant_kept", bus.grant, 3'b010);
    check_eq("pv_data_idle", bus.data, 9'h000);
    run_burst(1, 1, 0, -1, ne, nd);
    check_eq("pv_burst_done", nd, 1);
    bus.req = 3'b001;
    step();
    step();
    expect_grant("rst_grant");

    // Reset in the middle of a transfer.
    bus.data_in = DINW'($urandom);
    bus.en_in   = 3'b001;
    step();
    bus.en_in = '0;
    check_eq("rst_pre_write", bus.en_write, 1);
    bus.wr_done = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("async_reset");
    bus.wr_done = 1'b0;
    bus.req     = '0;
    step();
    rst = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
